// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
// Round sequencer for the falling-entity catch game. Decodes keyboard
// actions (START / PAUSE / ABORT) on key-change edges, tracks lives, the
// monotonic fall-speed level and the post-miss freeze, and emits a one-frame
// entity_reset pulse whenever a game starts or is abandoned.
//
// Ports
//   frame_clk       in   1  frame-rate clock, rising edge active
//   Reset           in   1  asynchronous, active-high reset
//   i_key           in   8  keyboard keycode, 0x00 when idle
//   i_score         in   8  current score from the entity table
//   i_miss          in   1  one-frame pulse: entity reached bottom uncaught
//   o_round_state   out  3  IDLE=0 PLAY=1 PAUSE=2 MISS=3 OVER=4
//   o_lives         out  2  lives remaining
//   o_lvl           out 10  fall step per frame (1..3)
//   o_run           out  1  high only in PLAY
//   o_entity_reset  out  1  one-frame pulse that clears the entity table
//   o_hiscore       out  8  best score (0 unless hiscore tracking is built)
//
// Build option
//   GAME_ROUND_HISCORE_EN : when defined, o_hiscore captures the score on
//   every entry to OVER if it beats the stored best; cleared only by Reset.
//   When undefined, o_hiscore is tied to zero and no register exists.
// ---------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int START_LIVES = 3,
  parameter int LVL2_SCORE  = 10,
  parameter int LVL3_SCORE  = 20,
  parameter int MISS_HOLD   = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] i_key,
  input  logic [7:0] i_score,
  input  logic       i_miss,
  output logic [2:0] o_round_state,
  output logic [1:0] o_lives,
  output logic [9:0] o_lvl,
  output logic       o_run,
  output logic       o_entity_reset,
  output logic [7:0] o_hiscore
);

  localparam logic [7:0] KEY_START  = 8'h28;
  localparam logic [7:0] KEY_PAUSE  = 8'h13;
  localparam logic [7:0] KEY_ABORT  = 8'h29;
  localparam logic [1:0] LIVES_INIT = START_LIVES[1:0];
  localparam logic [7:0] HOLD_INIT  = MISS_HOLD[7:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_lives;
  logic [1:0] w_nextLives;
  logic [9:0] r_lvl;
  logic [9:0] w_nextLvl;
  logic [9:0] w_scoreLvl;
  logic [7:0] r_hold;
  logic [7:0] w_nextHold;
  logic [7:0] r_prevKey;
  logic [7:0] w_keyAction;
  logic       r_run;
  logic       r_entityReset;
  logic       w_clearReq;

  // A key acts only in the frame it differs from last frame's code, so a
  // held key yields 0x00 here after its first frame and matches no action.
  assign w_keyAction = (i_key != r_prevKey) ? i_key : 8'h00;

  // Level implied by the current score alone; the FSM keeps the running max.
  always_comb begin
    w_scoreLvl = 10'd1;
    if (int'(i_score) >= LVL3_SCORE) begin
      w_scoreLvl = 10'd3;
    end else if (int'(i_score) >= LVL2_SCORE) begin
      w_scoreLvl = 10'd2;
    end
  end

  // Next-state logic. A miss in PLAY takes priority over any key action in
  // the same frame, so the PAUSE/ABORT edge is simply discarded.
  always_comb begin
    w_nextState = r_state;
    w_nextLives = r_lives;
    w_nextLvl   = r_lvl;
    w_nextHold  = r_hold;
    w_clearReq  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_keyAction == KEY_START) begin
          w_nextState = S_PLAY;
          w_nextLives = LIVES_INIT;
          w_nextLvl   = 10'd1;
          w_clearReq  = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_scoreLvl > r_lvl) begin
          w_nextLvl = w_scoreLvl;
        end
        if (i_miss) begin
          if (r_lives > 2'd1) begin
            w_nextLives = r_lives - 2'd1;
            w_nextHold  = HOLD_INIT;
            w_nextState = S_MISS;
          end else begin
            w_nextLives = 2'd0;
            w_nextState = S_OVER;
          end
        end else if (w_keyAction == KEY_ABORT) begin
          w_nextState = S_IDLE;
          w_clearReq  = 1'b1;
        end else if (w_keyAction == KEY_PAUSE) begin
          w_nextState = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_keyAction == KEY_ABORT) begin
          w_nextState = S_IDLE;
          w_clearReq  = 1'b1;
        end else if (w_keyAction == KEY_PAUSE) begin
          w_nextState = S_PLAY;
        end
      end
      S_MISS: begin
        // The <= also covers a zero count, so the freeze can never stick.
        if (r_hold <= 8'd1) begin
          w_nextHold  = 8'd0;
          w_nextState = S_PLAY;
        end else begin
          w_nextHold = r_hold - 8'd1;
        end
      end
      S_OVER: begin
        if (w_keyAction == KEY_START) begin
          w_nextState = S_IDLE;
          w_clearReq  = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State register. run is derived from the next state so it moves in the
  // same frame as round_state; entity_reset is suppressed if it was high
  // last frame (START immediately followed by ABORT).
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_lives       <= 2'd0;
      r_lvl         <= 10'd1;
      r_hold        <= 8'd0;
      r_prevKey     <= 8'h00;
      r_run         <= 1'b0;
      r_entityReset <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_lives       <= w_nextLives;
      r_lvl         <= w_nextLvl;
      r_hold        <= w_nextHold;
      r_prevKey     <= i_key;
      r_run         <= (w_nextState == S_PLAY);
      r_entityReset <= w_clearReq & ~r_entityReset;
    end
  end

`ifdef GAME_ROUND_HISCORE_EN
  logic [7:0] r_hiscore;

  // Best score is sampled on the PLAY->OVER transition only.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_hiscore <= 8'd0;
    end else if ((r_state == S_PLAY) && (w_nextState == S_OVER) &&
                 (i_score > r_hiscore)) begin
      r_hiscore <= i_score;
    end
  end

  assign o_hiscore = r_hiscore;
`else
  assign o_hiscore = 8'h00;
`endif

  assign o_round_state  = r_state;
  assign o_lives        = r_lives;
  assign o_lvl          = r_lvl;
  assign o_run          = r_run;
  assign o_entity_reset = r_entityReset;

endmodule
